memory_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Consumes execute_data_t: pc, ctl, result_alu, wa, plus the store operand srcb_fwd.
- Performs loads and stores over the data bus (dbus_req_t/dbus_resp_t) and produces memory_data_t for writeback.
- Owns the only multi-cycle wait in the back end and back-pressures execute through in_ready.

---
 rtl/memory_stage_pkg.sv | 72 +++++++
 rtl/memory_stage_if.sv | 27 ++
 rtl/memory_stage_mem_align.sv | 57 +++++
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared pipeline types for the memory stage.
//   - msize_t / ctl_t    : access size and the control bits the stage consumes
//   - execute_data_t     : execute -> memory payload (srcb_fwd is the store operand)
//   - memory_data_t      : memory -> writeback payload
//   - dbus_req_t/resp_t  : data bus request/response
//   - stage_state_t      : memory stage FSM encoding
//   - size_mask()        : byte-lane mask for an access size, before shifting
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memunsigned;
    msize_t msize;
  } ctl_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [63:0] result_alu;
    logic [4:0]  wa;
    logic [63:0] srcb_fwd;
  } execute_data_t;

  typedef struct packed {
    logic [63:0] pc;
    ctl_t        ctl;
    logic [4:0]  wa;
    logic [63:0] result;
    logic        misalign;
  } memory_data_t;

  // Data bus types; these mirror the common bus definitions.
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } stage_state_t;

  function automatic logic [7:0] size_mask(input msize_t size);
    case (size)
      MSIZE1:  size_mask = 8'h01;
      MSIZE2:  size_mask = 8'h03;
      MSIZE4:  size_mask = 8'h0F;
      MSIZE8:  size_mask = 8'hFF;
      default: size_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: bundles the memory stage's pipeline handshakes and data bus.
//   in_valid/in_ready/dataE    : upstream (execute) handshake
//   out_valid/out_ready/dataM  : downstream (writeback) handshake
//   dreq/dresp                 : data bus
// slave = the stage itself, master = its environment.
interface memory_stage_if;
  import memory_stage_pkg::*;

  logic          in_valid;
  logic          in_ready;
  execute_data_t dataE;
  logic          out_valid;
  logic          out_ready;
  memory_data_t  dataM;
  dbus_req_t     dreq;
  dbus_resp_t    dresp;

  modport slave (
    input  in_valid, dataE, out_ready, dresp,
    output in_ready, out_valid, dataM, dreq
  );

  modport master (
    output in_valid, dataE, out_ready, dresp,
    input  in_ready, out_valid, dataM, dreq
  );
endinterface

// File: rtl/memory_stage_mem_align.sv
// memory_stage_mem_align: combinational byte-lane alignment for the data bus.
//   addr        : low three bits of the effective address
//   size        : access size
//   wdata       : store operand, LSB-aligned
//   rdata       : raw 64-bit bus read data
//   is_unsigned : zero-extend instead of sign-extend the load result
//   strobe      : byte enables for a store
//   wdata_sh    : store data shifted onto its byte lanes
//   rdata_ext   : load result, shifted down and extended
//   misalign    : address not naturally aligned for this size
module memory_stage_mem_align
  import memory_stage_pkg::*;
(
  input  logic [2:0]  addr,
  input  msize_t      size,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  input  logic        is_unsigned,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext,
  output logic        misalign
);

  logic [5:0]  shamt_s;
  logic [63:0] rdata_sh_s;

  // Lane shifting, extension and alignment check for one access.
  always_comb begin
    shamt_s    = {addr, 3'b000};
    strobe     = size_mask(size) << addr;
    wdata_sh   = wdata << shamt_s;
    rdata_sh_s = rdata >> shamt_s;
    case (size)
      MSIZE1: begin
        misalign  = 1'b0;
        rdata_ext = is_unsigned ? {56'd0, rdata_sh_s[7:0]}
                                : {{56{rdata_sh_s[7]}}, rdata_sh_s[7:0]};
      end
      MSIZE2: begin
        misalign  = addr[0];
        rdata_ext = is_unsigned ? {48'd0, rdata_sh_s[15:0]}
                                : {{48{rdata_sh_s[15]}}, rdata_sh_s[15:0]};
      end
      MSIZE4: begin
        misalign  = |addr[1:0];
        rdata_ext = is_unsigned ? {32'd0, rdata_sh_s[31:0]}
                                : {{32{rdata_sh_s[31]}}, rdata_sh_s[31:0]};
      end
      default: begin
        misalign  = |addr;
        rdata_ext = rdata_sh_s;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage after execute; performs loads/stores on the
// data bus and hands memory_data_t to writeback.
//   clk, resetn : core clock, asynchronous active-low reset
//   io (slave)  : in_valid/in_ready/dataE upstream, out_valid/out_ready/dataM
//                 downstream, dreq/dresp data bus
// ADDR_ALIGN_CHECK=1 turns misaligned memory ops into non-bus ops that
// report misalign=1 and return the address as the result.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  memory_stage_if.slave   io
);

  stage_state_t state_q, state_d;
  logic         out_valid_q, out_valid_d;
  memory_data_t data_m_q, data_m_d;
  dbus_req_t    dreq_q, dreq_d;

  logic         in_ready_s;
  logic         accept_s;
  logic         is_mem_s;
  logic         misalign_s;
  logic         go_bus_s;
  logic         in_bus_s;

  logic [2:0]   al_addr_s;
  msize_t       al_size_s;
  logic         al_unsigned_s;
  logic [7:0]   al_strobe_s;
  logic [63:0]  al_wdata_s;
  logic [63:0]  al_rdata_s;
  logic         al_misalign_s;

  // The bus does not need addr_ok before data_ok, so it is never looked at.
  logic         addr_ok_unused;
  assign addr_ok_unused = io.dresp.addr_ok;

  assign in_ready_s = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && io.out_ready);
  assign accept_s   = io.in_valid && in_ready_s;
  assign in_bus_s   = (state_q == ST_BUS);
  assign is_mem_s   = io.dataE.ctl.memread || io.dataE.ctl.memwrite;
  assign misalign_s = ADDR_ALIGN_CHECK && is_mem_s && al_misalign_s;
  assign go_bus_s   = is_mem_s && !misalign_s;

  // Accept and BUS never overlap, so one aligner serves both: the incoming
  // op while not in BUS, the outstanding request while in BUS.
  always_comb begin
    if (in_bus_s) begin
      al_addr_s     = dreq_q.addr[2:0];
      al_size_s     = dreq_q.size;
      al_unsigned_s = data_m_q.ctl.memunsigned;
    end else begin
      al_addr_s     = io.dataE.result_alu[2:0];
      al_size_s     = io.dataE.ctl.msize;
      al_unsigned_s = io.dataE.ctl.memunsigned;
    end
  end

  memory_stage_mem_align u_align (
    .addr        (al_addr_s),
    .size        (al_size_s),
    .wdata       (io.dataE.srcb_fwd),
    .rdata       (io.dresp.data),
    .is_unsigned (al_unsigned_s),
    .strobe      (al_strobe_s),
    .wdata_sh    (al_wdata_s),
    .rdata_ext   (al_rdata_s),
    .misalign    (al_misalign_s)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      data_m_q    <= '0;
      dreq_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_m_q    <= data_m_d;
      dreq_q      <= dreq_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = go_bus_s ? ST_BUS : ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (io.dresp.data_ok) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_HOLD: begin
        if (accept_s) begin
          state_d = go_bus_s ? ST_BUS : ST_HOLD;
        end else if (io.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; data_ok outside BUS falls through to hold.
  always_comb begin
    out_valid_d = out_valid_q;
    data_m_d    = data_m_q;
    dreq_d      = dreq_q;
    if (accept_s) begin
      out_valid_d       = !go_bus_s;
      data_m_d.pc       = io.dataE.pc;
      data_m_d.ctl      = io.dataE.ctl;
      data_m_d.wa       = io.dataE.wa;
      data_m_d.misalign = misalign_s;
      data_m_d.result   = go_bus_s ? 64'd0 : io.dataE.result_alu;
      if (go_bus_s) begin
        dreq_d.valid  = 1'b1;
        dreq_d.addr   = io.dataE.result_alu;
        dreq_d.size   = io.dataE.ctl.msize;
        dreq_d.strobe = io.dataE.ctl.memwrite ? al_strobe_s : 8'h00;
        dreq_d.data   = io.dataE.ctl.memwrite ? al_wdata_s : 64'd0;
      end else begin
        dreq_d.valid  = 1'b0;
      end
    end else if (in_bus_s && io.dresp.data_ok) begin
      out_valid_d     = 1'b1;
      dreq_d.valid    = 1'b0;
      data_m_d.result = data_m_q.ctl.memread ? al_rdata_s : 64'd0;
    end else if ((state_q == ST_HOLD) && io.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  assign io.in_ready  = in_ready_s;
  assign io.out_valid = out_valid_q;
  assign io.dataM     = data_m_q;
  assign io.dreq      = dreq_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed stimulus with a scoreboard. The stimulus process
// pushes hand-computed results into a queue; a monitor pops and compares on
// every out_valid & out_ready, and checks dataM stability while stalled.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;

  memory_data_t sb_q[$];

  memory_stage_if ifc();

  memory_stage #(.ADDR_ALIGN_CHECK(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .io     (ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input ctl_t ctl, input logic [63:0] alu,
                       input logic [63:0] srcb, input logic [4:0] wa);
    ifc.in_valid            = 1'b1;
    ifc.dataE.pc            = pc;
    ifc.dataE.ctl           = ctl;
    ifc.dataE.result_alu    = alu;
    ifc.dataE.srcb_fwd      = srcb;
    ifc.dataE.wa            = wa;
  endtask

  task automatic expect_out(input logic [63:0] pc, input logic [4:0] wa,
                            input logic [63:0] result, input logic mis);
    memory_data_t e;
    e          = '0;
    e.pc       = pc;
    e.wa       = wa;
    e.result   = result;
    e.misalign = mis;
    sb_q.push_back(e);
  endtask

  function automatic ctl_t mk_ctl(input logic rd, input logic wr, input logic uns, input msize_t sz);
    ctl_t c;
    c             = '0;
    c.regwrite    = rd | ~wr;
    c.memread     = rd;
    c.memwrite    = wr;
    c.memunsigned = uns;
    c.msize       = sz;
    return c;
  endfunction

  // Scoreboard monitor.
  memory_data_t prev_m;
  logic         stalled = 1'b0;
  always @(negedge clk) begin
    memory_data_t e;
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("hold_pc_stable", ifc.dataM.pc, prev_m.pc);
        chk("hold_result_stable", ifc.dataM.result, prev_m.result);
      end
      if (ifc.out_valid && ifc.out_ready) begin
        stalled = 1'b0;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got out_valid pc=0x%h expected no output", ifc.dataM.pc);
        end else begin
          e = sb_q.pop_front();
          chk("out_pc", ifc.dataM.pc, e.pc);
          chk("out_wa", {59'd0, ifc.dataM.wa}, {59'd0, e.wa});
          chk("out_result", ifc.dataM.result, e.result);
          chk("out_misalign", {63'd0, ifc.dataM.misalign}, {63'd0, e.misalign});
        end
      end else if (ifc.out_valid) begin
        stalled = 1'b1;
        prev_m  = ifc.dataM;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.dataE     = '0;
    ifc.out_ready = 1'b1;
    ifc.dresp     = '0;
    resetn        = 1'b1;
    #2 resetn     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);
    chk("rst_dataM_pc", ifc.dataM.pc, 64'd0);
    chk("rst_dataM_result", ifc.dataM.result, 64'd0);
    cycle();
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);

    // ALU op, latency 1, no bus traffic.
    cycle();
    drive(64'h8000_0000, mk_ctl(1'b0, 1'b0, 1'b0, MSIZE1), 64'h5, 64'h0, 5'd3);
    expect_out(64'h8000_0000, 5'd3, 64'h5, 1'b0);
    @(negedge clk);
    chk("alu_out_valid_early", {63'd0, ifc.out_valid}, 64'd0);
    cycle();
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("alu_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    chk("alu_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);

    // Signed word load, data_ok on the third request cycle.
    cycle();
    drive(64'h8000_0010, mk_ctl(1'b1, 1'b0, 1'b0, MSIZE4), 64'h8000_0004, 64'h0, 5'd7);
    expect_out(64'h8000_0010, 5'd7, 64'hFFFF_FFFF_8000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      ifc.in_valid = 1'b0;
      if (i == 2) begin
        ifc.dresp.data_ok = 1'b1;
        ifc.dresp.data    = 64'h8000_0000_0000_0000;
      end
      @(negedge clk);
      chk("ld_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd1);
      chk("ld_dreq_addr", ifc.dreq.addr, 64'h8000_0004);
      chk("ld_dreq_size", {62'd0, ifc.dreq.size}, {62'd0, MSIZE4});
      chk("ld_dreq_strobe", {56'd0, ifc.dreq.strobe}, 64'd0);
      chk("ld_in_ready", {63'd0, ifc.in_ready}, 64'd0);
      chk("ld_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    end
    cycle();
    ifc.dresp = '0;
    @(negedge clk);
    chk("ld_done_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);
    chk("ld_done_out_valid", {63'd0, ifc.out_valid}, 64'd1);

    // Byte store, minimum latency.
    cycle();
    drive(64'h8000_0020, mk_ctl(1'b0, 1'b1, 1'b0, MSIZE1), 64'h8000_0003, 64'hAB, 5'd0);
    expect_out(64'h8000_0020, 5'd0, 64'h0, 1'b0);
    cycle();
    ifc.in_valid      = 1'b0;
    ifc.dresp.data_ok = 1'b1;
    @(negedge clk);
    chk("st_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd1);
    chk("st_dreq_strobe", {56'd0, ifc.dreq.strobe}, 64'h08);
    chk("st_dreq_data", ifc.dreq.data, 64'h0000_0000_AB00_0000);
    chk("st_dreq_addr", ifc.dreq.addr, 64'h8000_0003);
    cycle();
    ifc.dresp = '0;
    @(negedge clk);
    chk("st_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    chk("st_dreq_valid_drop", {63'd0, ifc.dreq.valid}, 64'd0);

    // Misaligned doubleword load: no bus request, address as result.
    cycle();
    drive(64'h8000_0030, mk_ctl(1'b1, 1'b0, 1'b0, MSIZE8), 64'h8000_0004, 64'h0, 5'd9);
    expect_out(64'h8000_0030, 5'd9, 64'h8000_0004, 1'b1);
    cycle();
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("mis_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    chk("mis_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);

    // Stall in HOLD for 4 cycles, then back-to-back handover.
    cycle();
    drive(64'h100, mk_ctl(1'b0, 1'b0, 1'b0, MSIZE1), 64'h1111, 64'h0, 5'd1);
    expect_out(64'h100, 5'd1, 64'h1111, 1'b0);
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      ifc.in_valid = 1'b0;
      @(negedge clk);
      chk("stall_out_valid", {63'd0, ifc.out_valid}, 64'd1);
      chk("stall_in_ready", {63'd0, ifc.in_ready}, 64'd0);
    end
    cycle();
    ifc.out_ready = 1'b1;
    drive(64'h104, mk_ctl(1'b0, 1'b0, 1'b0, MSIZE1), 64'h2222, 64'h0, 5'd2);
    expect_out(64'h104, 5'd2, 64'h2222, 1'b0);
    @(negedge clk);
    chk("b2b_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    // Retire the second op while a halfword unsigned load enters.
    cycle();
    drive(64'h108, mk_ctl(1'b1, 1'b0, 1'b1, MSIZE2), 64'h8000_0012, 64'h0, 5'd4);
    expect_out(64'h108, 5'd4, 64'h0000_0000_0000_BEEF, 1'b0);
    @(negedge clk);
    chk("b2b_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    cycle();
    ifc.in_valid      = 1'b0;
    ifc.dresp.data_ok = 1'b1;
    ifc.dresp.data    = 64'h0000_0000_BEEF_0000;
    @(negedge clk);
    chk("lh_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd1);
    chk("lh_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    cycle();
    ifc.dresp = '0;
    @(negedge clk);
    chk("lh_done_out_valid", {63'd0, ifc.out_valid}, 64'd1);

    // Reset while a request is outstanding; late data_ok must be ignored.
    cycle();
    drive(64'h200, mk_ctl(1'b1, 1'b0, 1'b0, MSIZE8), 64'h8000_0008, 64'h0, 5'd5);
    cycle();
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("rb_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rb_async_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);
    chk("rb_async_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    cycle();
    resetn = 1'b1;
    cycle();
    ifc.dresp.data_ok = 1'b1;
    ifc.dresp.data    = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("rb_late_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    cycle();
    ifc.dresp = '0;
    @(negedge clk);
    chk("rb_late_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rb_late_dreq_valid", {63'd0, ifc.dreq.valid}, 64'd0);
    cycle();
    @(negedge clk);
    chk("rb_idle_out_valid", {63'd0, ifc.out_valid}, 64'd0);

    cycle();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
